// File: rtl/mips_muldiv_unit_if.sv
// Handshake/result bundle between the core control path and the multiply/divide unit.
// The control path takes the master side. The unit takes the slave side.
interface mips_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [6:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit that owns HI/LO.
// It retires one bit per cycle, then applies a sign fixup before writing HI/LO.
module mips_muldiv_unit #(
  parameter int         WIDTH    = 32,
  parameter logic [6:0] OP_DIV   = 7'd7,
  parameter logic [6:0] OP_DIVU  = 7'd8,
  parameter logic [6:0] OP_MTHI  = 7'd11,
  parameter logic [6:0] OP_MTLO  = 7'd12,
  parameter logic [6:0] OP_MULT  = 7'd13,
  parameter logic [6:0] OP_MULTU = 7'd14
) (
  input  logic                clk,
  input  logic                reset,
  mips_muldiv_unit_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIXUP} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_count;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;

  logic               w_is_mult;
  logic               w_is_divop;
  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_is_mult  = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
  assign w_is_divop = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
  assign w_signed   = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign w_a_neg    = w_signed & bus.a[WIDTH-1];
  assign w_b_neg    = w_signed & bus.b[WIDTH-1];
  // The magnitude of the most negative value is 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  assign w_a_mag    = w_a_neg ? (~bus.a + 1'b1) : bus.a;
  assign w_b_mag    = w_b_neg ? (~bus.b + 1'b1) : bus.b;

  // Multiply: the upper half accumulates the multiplicand, and the multiplier shifts out of the lower half.
  assign w_addend   = r_acc[0] ? r_opnd : '0;
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

  // Divide: the upper half holds the remainder, and the lower half shifts the dividend out and the quotient in.
  assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_opnd};
  assign w_div_next = !w_diff[WIDTH] ? {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                                     : {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

  assign w_prod_fix = r_neg_q ? (~r_acc + 1'b1) : r_acc;
  assign w_quo_fix  = r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (w_is_mult || (w_is_divop && (bus.b != '0))) begin
              r_acc    <= {{WIDTH{1'b0}}, (w_is_mult ? w_b_mag : w_a_mag)};
              r_opnd   <= w_is_mult ? w_a_mag : w_b_mag;
              r_is_div <= w_is_divop;
              r_neg_q  <= w_a_neg ^ w_b_neg;
              r_neg_r  <= w_a_neg;
              r_count  <= '0;
              r_busy   <= 1'b1;
              r_state  <= S_ITER;
            end else if (w_is_divop) begin
              r_done <= 1'b1;
              r_dbz  <= 1'b1;
            end else if (bus.op == OP_MTHI) begin
              r_hi   <= bus.a;
              r_done <= 1'b1;
            end else if (bus.op == OP_MTLO) begin
              r_lo   <= bus.a;
              r_done <= 1'b1;
            end
          end
        end
        S_ITER: begin
          r_acc   <= r_is_div ? w_div_next : w_mul_next;
          r_count <= r_count + 1'b1;
          if (r_count == CW'(WIDTH-1)) r_state <= S_FIXUP;
        end
        S_FIXUP: begin
          r_hi    <= r_is_div ? w_rem_fix : w_prod_fix[2*WIDTH-1:WIDTH];
          r_lo    <= r_is_div ? w_quo_fix : w_prod_fix[WIDTH-1:0];
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: it uses directed corner cases plus random ops against an arithmetic reference model.
module tb_mips_muldiv_unit;
  localparam logic [6:0] OP_DIV   = 7'd7;
  localparam logic [6:0] OP_DIVU  = 7'd8;
  localparam logic [6:0] OP_MTHI  = 7'd11;
  localparam logic [6:0] OP_MTLO  = 7'd12;
  localparam logic [6:0] OP_MULT  = 7'd13;
  localparam logic [6:0] OP_MULTU = 7'd14;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic clk;
  logic reset;
  exp_t q[$];
  int   n_checks;
  int   n_fail;
  int   n_done;
  int   n_push;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mips_muldiv_unit_if #(.WIDTH(32)) ifc ();

  mips_muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: MIPS HI/LO semantics written as plain 64-bit arithmetic.
  task automatic model(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    longint      sq;
    longint      sr;
    e.dbz = 1'b0;
    case (op)
      OP_MULTU: begin
        p = {32'h0, a} * {32'h0, b};
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      OP_MULT: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      OP_DIVU: begin
        if (b == 0) e.dbz = 1'b1;
        else begin m_lo = a / b; m_hi = a % b; end
      end
      OP_DIV: begin
        if (b == 0) e.dbz = 1'b1;
        else begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          m_lo = sq[31:0]; m_hi = sr[31:0];
        end
      end
      OP_MTHI: m_hi = a;
      OP_MTLO: m_lo = a;
      default: return;
    endcase
    e.hi = m_hi;
    e.lo = m_lo;
    q.push_back(e);
    n_push++;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!ifc.busy) return;
    end
    n_checks++; n_fail++;
    $display("FAIL wait_idle: busy still 1 after 200 cycles");
  endtask

  task automatic issue(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b, input bit use_model);
    wait_idle();
    ifc.start = 1'b1; ifc.op = op; ifc.a = a; ifc.b = b;
    if (use_model) model(op, a, b);
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    ifc.op = 7'($urandom); ifc.a = $urandom; ifc.b = $urandom;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0000_0001;
      3: return 32'h0000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: it pops one expectation for every done pulse.
  always @(negedge clk) begin
    if (reset && ifc.done) begin
      n_done++;
      if (q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result_hi", {32'h0, ifc.hi}, {32'h0, e.hi});
        chk("result_lo", {32'h0, ifc.lo}, {32'h0, e.lo});
        chk("div_by_zero", {63'h0, ifc.div_by_zero}, {63'h0, e.dbz});
      end
    end
  end

  initial begin
    int bc;
    int k;
    int snap;
    logic [6:0] ops [8];
    ops = '{OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_MULT, OP_MULTU, 7'd0, 7'd5};
    n_checks = 0; n_fail = 0; n_done = 0; n_push = 0;
    m_hi = '0; m_lo = '0;
    reset = 1'b0;
    ifc.start = 1'b0; ifc.op = '0; ifc.a = '0; ifc.b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset_hi",   {32'h0, ifc.hi}, 64'h0);
    chk("reset_lo",   {32'h0, ifc.lo}, 64'h0);
    chk("reset_busy", {63'h0, ifc.busy}, 64'h0);
    chk("reset_done", {62'h0, ifc.done, ifc.div_by_zero}, 64'h0);

    // MULTU timing: busy is high for 33 cycles, and done arrives in cycle 34.
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    bc = 0; k = 0;
    while (k < 100) begin
      @(negedge clk);
      k++;
      if (ifc.done) break;
      if (ifc.busy) bc++;
    end
    chk("multu_busy_cycles", 64'(bc), 64'd33);
    chk("multu_done_cycle", 64'(k), 64'd34);
    chk("multu_busy_at_done", {63'h0, ifc.busy}, 64'h0);

    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1);
    issue(OP_DIV,  32'hFFFF_FFF9, 32'd2, 1);
    issue(OP_DIVU, 32'd100, 32'd7, 1);
    issue(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1);
    issue(OP_MTHI, 32'h1234, 32'h0, 1);
    issue(OP_MTLO, 32'h5678, 32'h0, 1);
    issue(OP_DIVU, 32'hDEAD, 32'h0, 1);
    wait_idle();
    @(negedge clk);
    chk("dbz_hi_kept", {32'h0, ifc.hi}, 64'h1234);
    chk("dbz_lo_kept", {32'h0, ifc.lo}, 64'h5678);

    // A second start during iteration must be ignored.
    issue(OP_MULTU, 32'h0001_2345, 32'h0006_789A, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    ifc.start = 1'b1; ifc.op = OP_DIV; ifc.a = 32'd99; ifc.b = 32'd3;
    @(negedge clk);
    ifc.start = 1'b0;

    for (int i = 0; i < 60; i++) begin
      logic [6:0] op;
      op = ops[$urandom_range(0, 7)];
      issue(op, pick(), pick(), 1);
    end
    wait_idle();

    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    chk("done_count", 64'(n_done), 64'(n_push));

    // Reset in the middle of an op clears HI/LO immediately and suppresses done.
    issue(OP_DIVU, 32'd1000, 32'd3, 0);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    #1;
    chk("midreset_hi",   {32'h0, ifc.hi}, 64'h0);
    chk("midreset_lo",   {32'h0, ifc.lo}, 64'h0);
    chk("midreset_busy", {63'h0, ifc.busy}, 64'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    snap = n_done;
    repeat (40) @(negedge clk);
    chk("midreset_no_done", 64'(n_done), 64'(snap));

    issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1);
    wait_idle();
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    chk("final_queue_drained", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
